// File: rtl/sdio_cmd_sequencer.sv
// SDIO command-layer sequencer: tracks card state and RCA, runs CMD52 register
// accesses over a per-function req/ack handshake, and builds the 40-bit responses.
module sdio_cmd_sequencer #(
    parameter int unsigned NUM_FUNCS   = 2,
    parameter int unsigned RSP_TIMEOUT = 32,
    parameter logic [15:0] DEFAULT_RCA = 16'h0001
) (
    input  logic                     sdio_clk_i,
    input  logic                     rst_i,
    input  logic                     cmd_stb_i,
    input  logic                     cmd_crc_good_stb_i,
    input  logic [5:0]               cmd_i,
    input  logic [31:0]              cmd_arg_i,
    output logic [39:0]              rsps_o,
    output logic [7:0]               rsps_len_o,
    output logic                     rsps_valid_o,
    output logic                     rsps_fail_o,
    input  logic [23:0]              ocr_i,
    output logic [NUM_FUNCS-1:0]     func_req_o,
    output logic                     func_write_o,
    output logic [16:0]              func_addr_o,
    output logic [7:0]               func_wdata_o,
    input  logic [NUM_FUNCS-1:0]     func_ack_i,
    input  logic [8*NUM_FUNCS-1:0]   func_rdata_i,
    output logic [1:0]               card_state_o,
    output logic [15:0]              rca_o
);

    typedef enum logic [1:0] {StIdle, StDecode, StAccess, StRespond} seq_state_e;
    typedef enum logic [1:0] {CsInit, CsReady, CsStby, CsSel} card_state_e;

    seq_state_e          state_q, state_d;
    card_state_e         cstate_q, cstate_d;
    logic [15:0]         rca_q, rca_d;
    logic [5:0]          cmd_q, cmd_d;
    logic [31:0]         arg_q, arg_d;
    logic                crc_ok_q, crc_ok_d;
    logic                crc_err_q, crc_err_d;
    logic                illegal_q, illegal_d;
    logic [39:0]         rsps_q, rsps_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                illegal_cmd;

    logic [2:0]           fn;
    logic                 fn_ok;
    logic [NUM_FUNCS-1:0] sel_oh;
    logic                 ack_hit;
    logic [7:0]           rdata_sel;
    logic                 unused_arg;

    function automatic logic [39:0] build_r5(input logic crc, input logic ill, input logic err,
                                             input logic fnerr, input logic [7:0] data);
        return {2'b00, 6'h34, 16'h0000, crc, ill, 2'b01, err, 1'b0, fnerr, 1'b0, data};
    endfunction

    assign fn         = arg_q[30:28];
    assign fn_ok      = 32'(fn) < NUM_FUNCS;
    assign sel_oh     = fn_ok ? (NUM_FUNCS'(1) << fn) : '0;
    assign ack_hit    = |(func_ack_i & sel_oh);
    assign unused_arg = ^{arg_q[26], arg_q[8]};

    always_comb begin
        rdata_sel = 8'h00;
        for (int f = 0; f < NUM_FUNCS; f++) begin
            if (sel_oh[f]) rdata_sel = func_rdata_i[8*f +: 8];
        end
    end

    always_comb begin
        state_d      = state_q;
        cstate_d     = cstate_q;
        rca_d        = rca_q;
        cmd_d        = cmd_q;
        arg_d        = arg_q;
        crc_ok_d     = crc_ok_q;
        crc_err_d    = crc_err_q;
        illegal_d    = illegal_q;
        rsps_d       = rsps_q;
        cnt_d        = cnt_q;
        illegal_cmd  = 1'b0;
        rsps_fail_o  = 1'b0;
        rsps_valid_o = 1'b0;
        func_req_o   = '0;

        unique case (state_q)
            StIdle: begin
                if (cmd_stb_i) begin
                    cmd_d    = cmd_i;
                    arg_d    = cmd_arg_i;
                    crc_ok_d = cmd_crc_good_stb_i;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                state_d = StIdle;
                if (!crc_ok_q) begin
                    rsps_fail_o = 1'b1;
                    crc_err_d   = 1'b1;
                end else begin
                    case (cmd_q)
                        6'd0: begin
                            cstate_d    = CsInit;
                            rca_d       = 16'h0000;
                            rsps_fail_o = 1'b1;
                        end
                        6'd5: begin
                            if (cstate_q != CsSel) begin
                                rsps_d = {8'h3F, 1'b1, 3'(NUM_FUNCS - 1), 1'b0, 3'b000, ocr_i};
                                if (cstate_q == CsInit && |(arg_q[23:0] & ocr_i)) begin
                                    cstate_d = CsReady;
                                end
                                state_d = StRespond;
                            end else begin
                                illegal_cmd = 1'b1;
                            end
                        end
                        6'd3: begin
                            if (cstate_q == CsReady) begin
                                rca_d    = DEFAULT_RCA;
                                cstate_d = CsStby;
                                rsps_d   = {8'h03, DEFAULT_RCA, 16'h0000};
                                state_d  = StRespond;
                            end else if (cstate_q == CsStby) begin
                                rsps_d  = {8'h03, rca_q, 16'h0000};
                                state_d = StRespond;
                            end else begin
                                illegal_cmd = 1'b1;
                            end
                        end
                        6'd7: begin
                            if (arg_q[31:16] == rca_q && cstate_q == CsStby) begin
                                cstate_d = CsSel;
                                rsps_d   = {8'h07, 32'h0000_0000};
                                state_d  = StRespond;
                            end else if (arg_q[31:16] != rca_q && cstate_q == CsSel) begin
                                // Deselect carries no response on the line.
                                cstate_d    = CsStby;
                                rsps_fail_o = 1'b1;
                            end else begin
                                illegal_cmd = 1'b1;
                            end
                        end
                        6'd52: begin
                            if (cstate_q != CsSel) begin
                                illegal_cmd = 1'b1;
                            end else if (fn_ok) begin
                                cnt_d   = 8'd0;
                                state_d = StAccess;
                            end else begin
                                rsps_d    = build_r5(crc_err_q, illegal_q, 1'b0, 1'b1, 8'h00);
                                crc_err_d = 1'b0;
                                illegal_d = 1'b0;
                                state_d   = StRespond;
                            end
                        end
                        default: illegal_cmd = 1'b1;
                    endcase
                    if (illegal_cmd) begin
                        rsps_fail_o = 1'b1;
                        illegal_d   = 1'b1;
                    end
                end
            end
            StAccess: begin
                func_req_o = sel_oh;
                if (ack_hit) begin
                    // RAW writes echo the value read back after the write.
                    rsps_d    = build_r5(crc_err_q, illegal_q, 1'b0, 1'b0,
                                         (!arg_q[31] || arg_q[27]) ? rdata_sel : 8'h00);
                    crc_err_d = 1'b0;
                    illegal_d = 1'b0;
                    state_d   = StRespond;
                end else if (cnt_q == 8'(RSP_TIMEOUT - 1)) begin
                    rsps_d    = build_r5(crc_err_q, illegal_q, 1'b1, 1'b0, 8'h00);
                    crc_err_d = 1'b0;
                    illegal_d = 1'b0;
                    state_d   = StRespond;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StRespond: begin
                rsps_valid_o = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sdio_clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cstate_q  <= CsInit;
            rca_q     <= 16'h0000;
            cmd_q     <= 6'd0;
            arg_q     <= 32'h0000_0000;
            crc_ok_q  <= 1'b0;
            crc_err_q <= 1'b0;
            illegal_q <= 1'b0;
            rsps_q    <= 40'h0;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            cstate_q  <= cstate_d;
            rca_q     <= rca_d;
            cmd_q     <= cmd_d;
            arg_q     <= arg_d;
            crc_ok_q  <= crc_ok_d;
            crc_err_q <= crc_err_d;
            illegal_q <= illegal_d;
            rsps_q    <= rsps_d;
            cnt_q     <= cnt_d;
        end
    end

    assign rsps_o       = rsps_q;
    assign rsps_len_o   = 8'd40;
    assign func_write_o = arg_q[31];
    assign func_addr_o  = arg_q[25:9];
    assign func_wdata_o = arg_q[7:0];
    assign card_state_o = cstate_q;
    assign rca_o        = rca_q;

endmodule

// File: tb/tb_sdio_cmd_sequencer.sv
// Directed bench for sdio_cmd_sequencer: card bring-up, CMD52 handshake,
// error flags, timeout, illegal commands and reset during an access.
module tb_sdio_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_stb;
    logic        cmd_crc_good_stb;
    logic [5:0]  cmd;
    logic [31:0] cmd_arg;
    logic [39:0] rsps;
    logic [7:0]  rsps_len;
    logic        rsps_valid;
    logic        rsps_fail;
    logic [23:0] ocr;
    logic [1:0]  func_req;
    logic        func_write;
    logic [16:0] func_addr;
    logic [7:0]  func_wdata;
    logic [1:0]  func_ack;
    logic [15:0] func_rdata;
    logic [1:0]  card_state;
    logic [15:0] rca;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sdio_cmd_sequencer #(
        .NUM_FUNCS  (2),
        .RSP_TIMEOUT(32),
        .DEFAULT_RCA(16'h0001)
    ) dut (
        .sdio_clk_i        (clk),
        .rst_i             (rst),
        .cmd_stb_i         (cmd_stb),
        .cmd_crc_good_stb_i(cmd_crc_good_stb),
        .cmd_i             (cmd),
        .cmd_arg_i         (cmd_arg),
        .rsps_o            (rsps),
        .rsps_len_o        (rsps_len),
        .rsps_valid_o      (rsps_valid),
        .rsps_fail_o       (rsps_fail),
        .ocr_i             (ocr),
        .func_req_o        (func_req),
        .func_write_o      (func_write),
        .func_addr_o       (func_addr),
        .func_wdata_o      (func_wdata),
        .func_ack_i        (func_ack),
        .func_rdata_i      (func_rdata),
        .card_state_o      (card_state),
        .rca_o             (rca)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] c52(input logic w, input logic [2:0] f, input logic raw,
                                        input logic [16:0] a, input logic [7:0] d);
        return {w, f, raw, 1'b0, a, 1'b0, d};
    endfunction

    // Returns just after the strobe edge T, where T+1 outputs are visible.
    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic good);
        step();
        cmd_stb          = 1'b1;
        cmd_crc_good_stb = good;
        cmd              = idx;
        cmd_arg          = arg;
        step();
        cmd_stb          = 1'b0;
        cmd_crc_good_stb = 1'b0;
    endtask

    // cycles = 1 means outcome visible at T+1, 2 at T+2, -1 if nothing came.
    task automatic wait_resp(output int cycles);
        cycles = 1;
        while (!(rsps_valid || rsps_fail) && cycles < 200) begin
            step();
            cycles++;
        end
        if (!(rsps_valid || rsps_fail)) cycles = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_tests++;
        if ({rsps, rsps_valid, rsps_fail, func_req, card_state, rca, func_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rsps=%h v=%b f=%b req=%b cs=%0d rca=%h addr=%h required all zero",
                     rsps, rsps_valid, rsps_fail, func_req, card_state, rca, func_addr);
        end
        n_tests++;
        if (rsps_len !== 8'd40) begin
            n_fail++;
            $display("FAIL reset_rsps_len: got %0d required 40", rsps_len);
        end
    endtask

    task automatic test_cmd5_init();
        int cyc;
        send_cmd(6'd5, 32'h0, 1'b1);
        wait_resp(cyc);
        n_tests++;
        if (cyc !== 2 || rsps_valid !== 1'b1 || rsps !== 40'h3F90FF8000) begin
            n_fail++;
            $display("FAIL cmd5_r4: got cyc=%0d v=%b rsps=%h required cyc=2 v=1 rsps=3f90ff8000",
                     cyc, rsps_valid, rsps);
        end
        n_tests++;
        if (card_state !== 2'd0) begin
            n_fail++;
            $display("FAIL cmd5_stays_init: got %0d required 0", card_state);
        end
    endtask

    task automatic test_bringup();
        int cyc;
        send_cmd(6'd5, 32'h0010_0000, 1'b1);
        wait_resp(cyc);
        n_tests++;
        if (cyc !== 2 || card_state !== 2'd1) begin
            n_fail++;
            $display("FAIL cmd5_ready: got cyc=%0d cs=%0d required cyc=2 cs=1", cyc, card_state);
        end
        send_cmd(6'd3, 32'h0, 1'b1);
        wait_resp(cyc);
        n_tests++;
        if (cyc !== 2 || rsps !== 40'h0300010000 || rca !== 16'h0001 || card_state !== 2'd2) begin
            n_fail++;
            $display("FAIL cmd3: got cyc=%0d rsps=%h rca=%h cs=%0d required 2 0300010000 0001 2",
                     cyc, rsps, rca, card_state);
        end
        send_cmd(6'd7, 32'h0001_0000, 1'b1);
        wait_resp(cyc);
        n_tests++;
        if (cyc !== 2 || rsps !== 40'h0700000000 || card_state !== 2'd3) begin
            n_fail++;
            $display("FAIL cmd7_select: got cyc=%0d rsps=%h cs=%0d required 2 0700000000 3",
                     cyc, rsps, card_state);
        end
    endtask

    task automatic test_cmd52_read();
        send_cmd(6'd52, c52(1'b0, 3'd1, 1'b0, 17'h00010, 8'h00), 1'b1);
        step();
        n_tests++;
        if (func_req !== 2'b10 || func_addr !== 17'h00010 || func_write !== 1'b0) begin
            n_fail++;
            $display("FAIL cmd52_req: got req=%b addr=%h w=%b required 10 00010 0",
                     func_req, func_addr, func_write);
        end
        func_ack = 2'b01;
        step();
        func_ack = 2'b00;
        n_tests++;
        if (func_req !== 2'b10 || rsps_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL cmd52_foreign_ack: got req=%b v=%b required 10 0", func_req, rsps_valid);
        end
        step();
        func_ack   = 2'b10;
        func_rdata = 16'hA500;
        step();
        func_ack = 2'b00;
        n_tests++;
        if (func_req !== 2'b00 || rsps_valid !== 1'b1 || rsps !== 40'h34000010A5) begin
            n_fail++;
            $display("FAIL cmd52_read_rsp: got req=%b v=%b rsps=%h required 00 1 34000010a5",
                     func_req, rsps_valid, rsps);
        end
    endtask

    task automatic test_crc_error();
        send_cmd(6'd52, c52(1'b0, 3'd1, 1'b0, 17'h00020, 8'h00), 1'b0);
        n_tests++;
        if (rsps_fail !== 1'b1 || func_req !== 2'b00) begin
            n_fail++;
            $display("FAIL crc_fail_pulse: got fail=%b req=%b required 1 00", rsps_fail, func_req);
        end
        step();
        n_tests++;
        if (func_req !== 2'b00 || rsps_fail !== 1'b0 || card_state !== 2'd3) begin
            n_fail++;
            $display("FAIL crc_no_req: got req=%b fail=%b cs=%0d required 00 0 3",
                     func_req, rsps_fail, card_state);
        end
        send_cmd(6'd52, c52(1'b0, 3'd1, 1'b0, 17'h00000, 8'h00), 1'b1);
        step();
        func_ack   = 2'b10;
        func_rdata = 16'h3C00;
        step();
        func_ack = 2'b00;
        n_tests++;
        if (rsps_valid !== 1'b1 || rsps !== 40'h340000903C) begin
            n_fail++;
            $display("FAIL crc_flag_r5: got v=%b rsps=%h required 1 340000903c", rsps_valid, rsps);
        end
    endtask

    task automatic test_func_errors();
        int cyc;
        int req_cycles;
        logic saw_req;
        send_cmd(6'd52, c52(1'b0, 3'd3, 1'b0, 17'h00001, 8'h00), 1'b1);
        saw_req = (func_req != 2'b00);
        wait_resp(cyc);
        n_tests++;
        if (cyc !== 2 || saw_req || func_req !== 2'b00 || rsps !== 40'h3400001200) begin
            n_fail++;
            $display("FAIL bad_function: got cyc=%0d saw_req=%b rsps=%h required 2 0 3400001200",
                     cyc, saw_req, rsps);
        end
        send_cmd(6'd52, c52(1'b1, 3'd1, 1'b0, 17'h1ABCD, 8'h5A), 1'b1);
        func_rdata = 16'hEE00;
        step();
        n_tests++;
        if (func_req !== 2'b10 || func_write !== 1'b1 || func_addr !== 17'h1ABCD ||
            func_wdata !== 8'h5A) begin
            n_fail++;
            $display("FAIL write_fields: got req=%b w=%b addr=%h wd=%h required 10 1 1abcd 5a",
                     func_req, func_write, func_addr, func_wdata);
        end
        req_cycles = 1;
        for (int i = 0; i < 100 && !rsps_valid; i++) begin
            step();
            if (func_req != 2'b00) req_cycles++;
        end
        n_tests++;
        if (req_cycles !== 32 || rsps_valid !== 1'b1 || rsps !== 40'h3400001800) begin
            n_fail++;
            $display("FAIL timeout: got req_cycles=%0d v=%b rsps=%h required 32 1 3400001800",
                     req_cycles, rsps_valid, rsps);
        end
    endtask

    task automatic test_raw_write();
        send_cmd(6'd52, c52(1'b1, 3'd1, 1'b1, 17'h00044, 8'h99), 1'b1);
        step();
        func_ack   = 2'b10;
        func_rdata = 16'h9900;
        step();
        func_ack = 2'b00;
        n_tests++;
        if (rsps_valid !== 1'b1 || rsps !== 40'h3400001099) begin
            n_fail++;
            $display("FAIL raw_write: got v=%b rsps=%h required 1 3400001099", rsps_valid, rsps);
        end
        send_cmd(6'd52, c52(1'b1, 3'd1, 1'b0, 17'h00045, 8'h11), 1'b1);
        step();
        func_ack   = 2'b10;
        func_rdata = 16'h7700;
        step();
        func_ack = 2'b00;
        n_tests++;
        if (rsps_valid !== 1'b1 || rsps !== 40'h3400001000) begin
            n_fail++;
            $display("FAIL plain_write: got v=%b rsps=%h required 1 3400001000", rsps_valid, rsps);
        end
    endtask

    task automatic test_stby_illegal();
        int cyc;
        send_cmd(6'd7, 32'h0002_0000, 1'b1);
        wait_resp(cyc);
        n_tests++;
        if (cyc !== 1 || rsps_fail !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd7_deselect: got cyc=%0d fail=%b required 1 1", cyc, rsps_fail);
        end
        step();
        n_tests++;
        if (card_state !== 2'd2) begin
            n_fail++;
            $display("FAIL deselect_state: got %0d required 2", card_state);
        end
        send_cmd(6'd52, c52(1'b0, 3'd0, 1'b0, 17'h00000, 8'h00), 1'b1);
        wait_resp(cyc);
        n_tests++;
        if (cyc !== 1 || rsps_fail !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd52_in_stby: got cyc=%0d fail=%b required 1 1", cyc, rsps_fail);
        end
        send_cmd(6'd7, 32'h0001_0000, 1'b1);
        wait_resp(cyc);
        send_cmd(6'd52, c52(1'b0, 3'd0, 1'b0, 17'h00008, 8'h00), 1'b1);
        step();
        n_tests++;
        if (func_req !== 2'b01) begin
            n_fail++;
            $display("FAIL fn0_req: got %b required 01", func_req);
        end
        func_ack   = 2'b01;
        func_rdata = 16'h0077;
        step();
        func_ack = 2'b00;
        n_tests++;
        if (rsps_valid !== 1'b1 || rsps !== 40'h3400005077) begin
            n_fail++;
            $display("FAIL illegal_flag_r5: got v=%b rsps=%h required 1 3400005077",
                     rsps_valid, rsps);
        end
    endtask

    task automatic test_reset_mid_access();
        send_cmd(6'd52, c52(1'b0, 3'd1, 1'b0, 17'h00003, 8'h00), 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if (func_req !== 2'b00 || card_state !== 2'd0 || rca !== 16'h0 ||
            rsps_valid !== 1'b0 || rsps_fail !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_access: got req=%b cs=%0d rca=%h v=%b f=%b required 00 0 0 0 0",
                     func_req, card_state, rca, rsps_valid, rsps_fail);
        end
    endtask

    task automatic test_back_to_back();
        logic extra;
        send_cmd(6'd5, 32'h0, 1'b1);
        cmd_stb          = 1'b1;
        cmd_crc_good_stb = 1'b1;
        cmd              = 6'd3;
        step();
        cmd_stb          = 1'b0;
        cmd_crc_good_stb = 1'b0;
        n_tests++;
        if (rsps_valid !== 1'b1 || rsps !== 40'h3F90FF8000) begin
            n_fail++;
            $display("FAIL stb_busy_ignored: got v=%b rsps=%h required 1 3f90ff8000",
                     rsps_valid, rsps);
        end
        extra = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (rsps_valid || rsps_fail) extra = 1'b1;
        end
        n_tests++;
        if (extra !== 1'b0) begin
            n_fail++;
            $display("FAIL stb_busy_no_extra: got %b required 0", extra);
        end
    endtask

    task automatic test_cmd0_and_unknown();
        int cyc;
        send_cmd(6'd5, 32'h0010_0000, 1'b1);
        wait_resp(cyc);
        send_cmd(6'd3, 32'h0, 1'b1);
        wait_resp(cyc);
        send_cmd(6'd0, 32'h0, 1'b1);
        wait_resp(cyc);
        n_tests++;
        if (cyc !== 1 || rsps_fail !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd0_fail: got cyc=%0d fail=%b required 1 1", cyc, rsps_fail);
        end
        step();
        n_tests++;
        if (card_state !== 2'd0 || rca !== 16'h0000) begin
            n_fail++;
            $display("FAIL cmd0_state: got cs=%0d rca=%h required 0 0000", card_state, rca);
        end
        send_cmd(6'd8, 32'h0, 1'b1);
        wait_resp(cyc);
        n_tests++;
        if (cyc !== 1 || rsps_fail !== 1'b1) begin
            n_fail++;
            $display("FAIL unknown_cmd: got cyc=%0d fail=%b required 1 1", cyc, rsps_fail);
        end
    endtask

    initial begin
        rst              = 1'b1;
        cmd_stb          = 1'b0;
        cmd_crc_good_stb = 1'b0;
        cmd              = 6'd0;
        cmd_arg          = 32'h0;
        ocr              = 24'hFF8000;
        func_ack         = 2'b00;
        func_rdata       = 16'h0000;
        test_reset();
        test_cmd5_init();
        test_bringup();
        test_cmd52_read();
        test_crc_error();
        test_func_errors();
        test_raw_write();
        test_stby_illegal();
        test_reset_mid_access();
        test_back_to_back();
        test_cmd0_and_unknown();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
